full_subtractor: RTL and testbench

//   Registered full subtractor: computes Diff = A - B - Cin and a borrow-out.

---
 rtl/full_subtractor.sv | 52 +++++
 tb/tb_full_subtractor.sv | 138 +++++++++++++
 2 files changed

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - borrow-ripple full subtractor with optional output register
module full_subtractor #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             out_valid
);

  logic [WIDTH-1:0] diff_c;
  logic             borrow_c;

  // Borrow ripples from bit 0 upward; br carries b_i into cell i.
  always_comb begin : ripple
    logic br;
    diff_c = '0;
    br     = Cin;
    for (int i = 0; i < WIDTH; i++) begin
      diff_c[i] = A[i] ^ B[i] ^ br;
      br        = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & br);
    end
    borrow_c = br;
  end

  if (REG_OUT) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        Diff      <= '0;
        Borrow    <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        Diff      <= diff_c;
        Borrow    <= borrow_c;
        out_valid <= in_valid;
      end
    end
  end else begin : g_comb
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst_n};
    assign Diff        = diff_c;
    assign Borrow      = borrow_c;
    assign out_valid   = in_valid;
  end

endmodule

// File: tb/tb_full_subtractor.sv
// tb/tb_full_subtractor.sv - random and directed checks of full_subtractor against an arithmetic model
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a1, b1, c1, v1;
  logic [7:0] a8, b8;
  logic       c8, v8;

  logic       d1o, bo1o, vo1;
  logic [7:0] d8o;
  logic       bo8o, vo8;
  logic       d0o, bo0o, vo0;

  full_subtractor #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1), .Cin(c1),
    .Diff(d1o), .Borrow(bo1o), .out_valid(vo1));

  full_subtractor #(.WIDTH(8), .REG_OUT(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8), .Cin(c8),
    .Diff(d8o), .Borrow(bo8o), .out_valid(vo8));

  full_subtractor #(.WIDTH(1), .REG_OUT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1), .Cin(c1),
    .Diff(d0o), .Borrow(bo0o), .out_valid(vo0));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // {borrow, diff} as the low w+1 bits of the integer difference
  function automatic logic [8:0] model(input int w, input int a, input int b, input int cin);
    int r;
    r = a - b - cin;
    return 9'(r & ((1 << (w + 1)) - 1));
  endfunction

  logic [8:0] e1 = '0, e8 = '0;
  logic       ev1 = 1'b0, ev8 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1 <= '0; e8 <= '0; ev1 <= 1'b0; ev8 <= 1'b0;
    end else begin
      e1  <= model(1, int'(a1), int'(b1), int'(c1));
      e8  <= model(8, int'(a8), int'(b8), int'(c8));
      ev1 <= v1;
      ev8 <= v8;
    end
  end

  always @(negedge clk) begin
    chk("w1_reg_result", {7'b0, bo1o, d1o}, e1);
    chk("w1_reg_valid", {8'b0, vo1}, {8'b0, ev1});
    chk("w8_reg_result", {bo8o, d8o}, e8);
    chk("w8_reg_valid", {8'b0, vo8}, {8'b0, ev8});
    chk("w1_comb_result", {7'b0, bo0o, d0o}, model(1, int'(a1), int'(b1), int'(c1)));
    chk("w1_comb_valid", {8'b0, vo0}, {8'b0, v1});
  end

  // {Diff, Borrow} for (A,B,Cin) = 000..111
  logic [1:0] tbl [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  initial begin
    logic [2:0] idx;
    rst_n = 1'b0;
    a1 = 0; b1 = 0; c1 = 0; v1 = 0;
    a8 = 0; b8 = 0; c8 = 0; v8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_w1", {6'b0, d1o, bo1o, vo1}, 9'h0);
    chk("reset_w8", {bo8o, d8o}, 9'h0);
    chk("reset_w8_valid", {8'b0, vo8}, 9'h0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      idx = 3'(i);
      a1 = idx[2]; b1 = idx[1]; c1 = idx[0]; v1 = 1'b1;
      #1 chk("truth_comb", {7'b0, d0o, bo0o}, {7'b0, tbl[i]});
      @(posedge clk); #1;
      chk("truth_reg", {7'b0, d1o, bo1o}, {7'b0, tbl[i]});
      chk("truth_reg_valid", {8'b0, vo1}, 9'h1);
    end

    @(posedge clk); #2;
    a1 = 1; b1 = 0; c1 = 0; v1 = 0;
    @(posedge clk); #2;
    v1 = 1;
    #1 chk("latency_not_early", {8'b0, vo1}, 9'h0);
    @(posedge clk); #1;
    chk("latency_result", {6'b0, d1o, bo1o, vo1}, 9'b0_0000_0101);

    #1 rst_n = 1'b0;
    #1 chk("async_reset", {6'b0, d1o, bo1o, vo1}, 9'h0);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", {6'b0, d1o, bo1o, vo1}, 9'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_after_release", {6'b0, d1o, bo1o, vo1}, 9'b0_0000_0101);

    @(posedge clk); #2;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
    @(posedge clk); #1;
    chk("w8_wrap", {bo8o, d8o}, 9'h1FF);
    #1 a8 = 8'h5A; b8 = 8'h3C; c8 = 1'b0;
    @(posedge clk); #1;
    chk("w8_5a_3c", {bo8o, d8o}, 9'h01E);
    #1 a8 = 8'hFF; b8 = 8'h00; c8 = 1'b0;
    @(posedge clk); #1;
    chk("w8_allones", {bo8o, d8o}, 9'h0FF);
    #1 a8 = 8'h77; b8 = 8'h77; c8 = 1'b0;
    @(posedge clk); #1;
    chk("w8_equal", {bo8o, d8o}, 9'h000);

    for (int n = 0; n < 10000; n++) begin
      @(posedge clk); #2;
      a8 = 8'($urandom); b8 = 8'($urandom);
      c8 = 1'($urandom); v8 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom);
      c1 = 1'($urandom); v1 = 1'($urandom);
    end
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
